// File: rtl/noc_sync_endpoint.sv
// Clocked endpoint bridging a synchronous PE to a router's asynchronous local port.
// Tx: FIFO plus a 4-phase initiator. Rx: a 4-phase responder feeding a FIFO.
module noc_sync_endpoint #(
   parameter int         WIDTH    = 12,
   parameter logic [2:0] MY_ADDR  = 3'd0,
   parameter int         TX_DEPTH = 4,
   parameter int         RX_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [2:0]       tx_dest,
   input  logic [WIDTH-7:0] tx_payload,
   output logic             net_tx_req,
   output logic [WIDTH-1:0] net_tx_data,
   input  logic             net_tx_ack,
   input  logic             net_rx_req,
   input  logic [WIDTH-1:0] net_rx_data,
   output logic             net_rx_ack,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [2:0]       rx_src,
   output logic [WIDTH-7:0] rx_payload,
   output logic [15:0]      tx_count,
   output logic [15:0]      rx_count,
   output logic [7:0]       misroute_count
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);

   typedef enum logic [1:0] {T_IDLE, T_SETUP, T_REQ, T_REL} tx_state_t;
   typedef enum logic       {R_WAIT, R_ACK} rx_state_t;

   tx_state_t tx_state, tx_next;
   rx_state_t rx_state, rx_next;

   logic [1:0] ack_sync, req_sync;
   logic       ack_s, req_s;

   logic [WIDTH-1:0] tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_AW:0]   tx_cnt;
   logic             ready_q, tx_push, tx_pop, tx_done;

   // Destination bits are consumed at capture, so only source and payload are stored.
   logic [WIDTH-4:0] rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_AW:0]   rx_cnt;
   logic             rx_cap, rx_pop;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_sync <= '0;
         req_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[0], net_tx_ack};
         req_sync <= {req_sync[0], net_rx_req};
      end
   end

   assign ack_s = ack_sync[1];
   assign req_s = req_sync[1];

   // ready_q keeps tx_ready low while reset is asserted.
   assign tx_ready = ready_q & (tx_cnt != TX_FULL);
   assign tx_push  = tx_valid & tx_ready;

   // NOTE: FIFO storage has no reset; pointers and counts alone define validity.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= {tx_payload, MY_ADDR, tx_dest};
      if (rx_cap)  rx_mem[rx_wr_ptr] <= net_rx_data[WIDTH-1:3];
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      tx_done = 1'b0;
      unique case (tx_state)
         T_IDLE:  if (tx_cnt != '0) begin
                     tx_pop  = 1'b1;
                     tx_next = T_SETUP;
                  end
         T_SETUP: tx_next = T_REQ;
         T_REQ:   if (ack_s) tx_next = T_REL;
         T_REL:   if (!ack_s) begin
                     tx_done = 1'b1;
                     tx_next = T_IDLE;
                  end
         default: tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state    <= T_IDLE;
         ready_q     <= 1'b0;
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_cnt      <= '0;
         net_tx_req  <= 1'b0;
         net_tx_data <= '0;
         tx_count    <= '0;
      end else begin
         tx_state   <= tx_next;
         ready_q    <= 1'b1;
         net_tx_req <= (tx_next == T_REQ);
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop) begin
            tx_rd_ptr   <= tx_rd_ptr + 1'b1;
            net_tx_data <= tx_mem[tx_rd_ptr];
         end
         tx_cnt <= tx_cnt + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
         if (tx_done) tx_count <= tx_count + 16'd1;
      end
   end

   // Occupancy test uses the pre-pop count, so a full FIFO being popped captures next cycle.
   always_comb begin
      rx_next = rx_state;
      rx_cap  = 1'b0;
      unique case (rx_state)
         R_WAIT:  if (req_s && (rx_cnt != RX_FULL)) begin
                     rx_cap  = 1'b1;
                     rx_next = R_ACK;
                  end
         R_ACK:   if (!req_s) rx_next = R_WAIT;
         default: rx_next = R_WAIT;
      endcase
   end

   assign rx_valid   = (rx_cnt != '0);
   assign rx_pop     = rx_valid & rx_ready;
   assign rx_src     = rx_valid ? rx_mem[rx_rd_ptr][2:0] : 3'd0;
   assign rx_payload = rx_valid ? rx_mem[rx_rd_ptr][WIDTH-4:3] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state       <= R_WAIT;
         rx_wr_ptr      <= '0;
         rx_rd_ptr      <= '0;
         rx_cnt         <= '0;
         net_rx_ack     <= 1'b0;
         rx_count       <= '0;
         misroute_count <= '0;
      end else begin
         rx_state   <= rx_next;
         net_rx_ack <= (rx_next == R_ACK);
         if (rx_cap) begin
            rx_wr_ptr <= rx_wr_ptr + 1'b1;
            rx_count  <= rx_count + 16'd1;
            if ((net_rx_data[2:0] != MY_ADDR) && (misroute_count != 8'hFF))
               misroute_count <= misroute_count + 8'd1;
         end
         if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
         rx_cnt <= rx_cnt + (RX_AW+1)'(rx_cap) - (RX_AW+1)'(rx_pop);
      end
   end

endmodule

// File: tb/tb_noc_sync_endpoint.sv
// Directed bench for noc_sync_endpoint with MY_ADDR=2; the bench plays the router on both
// handshake ports and checks against hand-computed packet values.
module tb_noc_sync_endpoint;

   localparam int         WIDTH = 12;
   localparam logic [2:0] MY    = 3'd2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tx_valid, tx_ready;
   logic [2:0]       tx_dest;
   logic [5:0]       tx_payload;
   logic             net_tx_req, net_tx_ack;
   logic [WIDTH-1:0] net_tx_data;
   logic             net_rx_req, net_rx_ack;
   logic [WIDTH-1:0] net_rx_data;
   logic             rx_valid, rx_ready;
   logic [2:0]       rx_src;
   logic [5:0]       rx_payload;
   logic [15:0]      tx_count, rx_count;
   logic [7:0]       misroute_count;

   noc_sync_endpoint #(.WIDTH(WIDTH), .MY_ADDR(MY), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_payload(tx_payload),
      .net_tx_req(net_tx_req), .net_tx_data(net_tx_data), .net_tx_ack(net_tx_ack),
      .net_rx_req(net_rx_req), .net_rx_data(net_rx_data), .net_rx_ack(net_rx_ack),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_payload(rx_payload),
      .tx_count(tx_count), .rx_count(rx_count), .misroute_count(misroute_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  dest;
      logic [5:0]  pl;
      logic [11:0] exp;
   } tx_vec_t;

   typedef struct {
      logic [11:0] data;
      logic [2:0]  src;
      logic [5:0]  pl;
      logic        mis;
   } rx_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push_tx(input logic [2:0] dest, input logic [5:0] pl, output int stalls);
      int budget = 1000;
      stalls = 0;
      tx_dest = dest;
      tx_payload = pl;
      tx_valid = 1'b1;
      while (!tx_ready && budget > 0) begin
         tick();
         stalls++;
         budget--;
      end
      if (budget == 0) check("push_tx_timeout", tx_ready, 1);
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic router_tx_accept(input int delay, output logic [WIDTH-1:0] data);
      int budget = 2000;
      while (!net_tx_req && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("tx_req_timeout", net_tx_req, 1);
      data = net_tx_data;
      ticks(delay);
      net_tx_ack = 1'b1;
      budget = 100;
      while (net_tx_req && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("tx_req_fall_timeout", net_tx_req, 0);
      net_tx_ack = 1'b0;
   endtask

   task automatic rx_start(input logic [WIDTH-1:0] d);
      net_rx_data = d;
      net_rx_req = 1'b1;
   endtask

   task automatic rx_wait_ack(input int budget, output logic got);
      while (!net_rx_ack && budget > 0) begin
         tick();
         budget--;
      end
      got = net_rx_ack;
   endtask

   task automatic rx_finish();
      int budget = 100;
      net_rx_req = 1'b0;
      while (net_rx_ack && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("rx_ack_fall_timeout", net_rx_ack, 0);
   endtask

   task automatic rx_send(input logic [WIDTH-1:0] d);
      logic got;
      rx_start(d);
      rx_wait_ack(100, got);
      if (!got) check("rx_ack_timeout", got, 1);
      rx_finish();
   endtask

   task automatic pop_rx(output logic [2:0] src, output logic [5:0] pl);
      src = rx_src;
      pl = rx_payload;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_vec_t          tx_tab [4];
      rx_vec_t          rx_tab [4];
      logic [WIDTH-1:0] d;
      logic [2:0]       s;
      logic [5:0]       p;
      logic             got;
      int               stalls;
      int               first_stall;
      int               exp_mis;

      tx_tab[0] = '{3'd0, 6'h00, 12'h010};
      tx_tab[1] = '{3'd7, 6'h3F, 12'hFD7};
      tx_tab[2] = '{3'd2, 6'h15, 12'h552};
      tx_tab[3] = '{3'd1, 6'h2A, 12'hA91};
      rx_tab[0] = '{12'h552, 3'd2, 6'h15, 1'b0};
      rx_tab[1] = '{12'hFD7, 3'd2, 6'h3F, 1'b1};
      rx_tab[2] = '{12'h123, 3'd4, 6'h04, 1'b1};
      rx_tab[3] = '{12'h0AA, 3'd5, 6'h02, 1'b0};

      rst_n = 1'b0;
      tx_valid = 1'b0; tx_dest = '0; tx_payload = '0;
      net_tx_ack = 1'b0; net_rx_req = 1'b0; net_rx_data = '0; rx_ready = 1'b0;
      ticks(3);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_tx_req", net_tx_req, 0);
      check("rst_tx_data", net_tx_data, 0);
      check("rst_rx_ack", net_rx_ack, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_counts", {tx_count, rx_count}, 0);
      check("rst_misroute", misroute_count, 0);
      rst_n = 1'b1;
      tick();
      check("rel_tx_ready", tx_ready, 1);

      // Single tx with exact edge timing.
      tx_dest = 3'd5; tx_payload = 6'h2A; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("single_req_at_push", net_tx_req, 0);
      tick();
      check("single_data", net_tx_data, 12'hA95);
      check("single_req_n1", net_tx_req, 0);
      tick();
      check("single_req_n2", net_tx_req, 1);
      net_tx_ack = 1'b1;
      ticks(2);
      check("single_req_held", net_tx_req, 1);
      tick();
      check("single_req_fall", net_tx_req, 0);
      net_tx_ack = 1'b0;
      ticks(2);
      check("single_count_early", tx_count, 0);
      tick();
      check("single_count", tx_count, 1);

      // Table-driven tx packets.
      for (int i = 0; i < 4; i++) begin
         push_tx(tx_tab[i].dest, tx_tab[i].pl, stalls);
         router_tx_accept(0, d);
         check($sformatf("tx_vec%0d_data", i), d, tx_tab[i].exp);
      end
      ticks(4);
      check("tx_vec_count", tx_count, 5);

      // Table-driven rx packets, including misrouted ones.
      exp_mis = 0;
      for (int i = 0; i < 4; i++) begin
         rx_send(rx_tab[i].data);
         exp_mis += int'(rx_tab[i].mis);
         check($sformatf("rx_vec%0d_valid", i), rx_valid, 1);
         check($sformatf("rx_vec%0d_src", i), rx_src, rx_tab[i].src);
         check($sformatf("rx_vec%0d_payload", i), rx_payload, rx_tab[i].pl);
         check($sformatf("rx_vec%0d_misroute", i), misroute_count, exp_mis);
         pop_rx(s, p);
      end
      check("rx_vec_empty", rx_valid, 0);
      check("rx_vec_count", rx_count, 4);

      // Burst of 6 against a slow responder.
      first_stall = -1;
      fork
         begin
            int st;
            for (int i = 0; i < 6; i++) begin
               push_tx(3'(i), 6'(8'h10 + i), st);
               if (st > 0 && first_stall < 0) first_stall = i;
            end
         end
         begin
            logic [WIDTH-1:0] dd;
            for (int i = 0; i < 6; i++) begin
               router_tx_accept(10, dd);
               check($sformatf("burst%0d_data", i), dd, {6'(8'h10 + i), MY, 3'(i)});
            end
         end
      join
      check("burst_stall_point", (first_stall == 4 || first_stall == 5), 1);
      ticks(4);
      check("burst_count", tx_count, 11);

      // Rx backpressure: four fill the FIFO, the fifth waits for a pop.
      for (int i = 0; i < 4; i++) rx_send({6'(i + 1), 3'd1, MY});
      rx_start({6'd5, 3'd1, MY});
      rx_wait_ack(30, got);
      check("rx_full_no_ack", got, 0);
      check("rx_full_count", rx_count, 8);
      pop_rx(s, p);
      check("rx_full_pop_payload", p, 1);
      rx_wait_ack(20, got);
      check("rx_ack_after_pop", got, 1);
      rx_finish();
      check("rx_bp_count", rx_count, 9);
      for (int i = 0; i < 4; i++) begin
         pop_rx(s, p);
         check($sformatf("rx_bp%0d_payload", i), p, i + 2);
      end
      check("rx_bp_empty", rx_valid, 0);

      // Misroute saturation with continuous popping.
      rx_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rx_send({6'(i), 3'd6, 3'd3});
         if (i == 199) check("misroute_202", misroute_count, 202);
      end
      rx_ready = 1'b0;
      ticks(2);
      check("misroute_sat", misroute_count, 255);
      check("misroute_rx_count", rx_count, 309);
      check("misroute_drained", rx_valid, 0);

      // Reset with both handshakes in flight.
      push_tx(3'd1, 6'd3, stalls);
      ticks(3);
      check("midrst_req_high", net_tx_req, 1);
      rx_start(12'h0AA);
      rx_wait_ack(20, got);
      check("midrst_rx_ack", got, 1);
      rst_n = 1'b0;
      net_rx_req = 1'b0;
      tick();
      check("midrst_tx_req", net_tx_req, 0);
      check("midrst_rx_ack_low", net_rx_ack, 0);
      check("midrst_counts", {tx_count, rx_count}, 0);
      check("midrst_misroute", misroute_count, 0);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_tx_ready", tx_ready, 0);
      rst_n = 1'b1;
      tick();
      check("midrst_rel_ready", tx_ready, 1);
      ticks(5);
      check("midrst_idle_req", net_tx_req, 0);

      // Concurrent tx and rx streams.
      fork
         begin
            int st;
            for (int i = 0; i < 20; i++) push_tx(3'(i % 8), 6'(i * 3), st);
         end
         begin
            logic [WIDTH-1:0] dd;
            for (int i = 0; i < 20; i++) begin
               router_tx_accept(i % 4, dd);
               check($sformatf("conc_tx%0d", i), dd, {6'(i * 3), MY, 3'(i % 8)});
            end
         end
         begin
            for (int i = 0; i < 20; i++) rx_send({6'(i + 7), 3'(i % 8), MY});
         end
         begin
            logic [2:0] ss;
            logic [5:0] pp;
            for (int i = 0; i < 20; i++) begin
               int budget = 300;
               while (!rx_valid && budget > 0) begin
                  tick();
                  budget--;
               end
               if (budget == 0) check("conc_rx_timeout", rx_valid, 1);
               pop_rx(ss, pp);
               check($sformatf("conc_rx%0d", i), {ss, pp}, {3'(i % 8), 6'(i + 7)});
               ticks(i % 3);
            end
         end
      join
      ticks(5);
      check("conc_tx_count", tx_count, 20);
      check("conc_rx_count", rx_count, 20);
      check("conc_misroute", misroute_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
